// File: rtl/alu_op_sequencer_if.sv
// Bus bundle for alu_op_sequencer: program load, run control, ALU drive/return and result report.
// The err line exists only when ALU_SEQ_ONEHOT_CHECK_EN is defined.
interface alu_op_sequencer_if #(
    parameter int DEPTH = 8
);
    localparam int IDX_W = $clog2(DEPTH);

    // wr_en, prog_clr and start are single-cycle requests without a ready: they take
    // effect only when the sequencer is idle (wr_en also needs !prog_full); res_valid
    // and done are one-cycle pulses with no backpressure.
    logic             wr_en;
    logic [7:0]       wr_num1;
    logic [7:0]       wr_num2;
    logic [6:0]       wr_op;
    logic             prog_clr;
    logic             start;
    logic [7:0]       alu_out;
    logic             on;
    logic [2:0]       in_sel;
    logic [7:0]       num1;
    logic [7:0]       num2;
    logic [6:0]       out_sel;
    logic             res_valid;
    logic [7:0]       res_data;
    logic [IDX_W-1:0] res_idx;
    logic             busy;
    logic             done;
    logic             prog_full;
    logic [IDX_W:0]   prog_cnt;
`ifdef ALU_SEQ_ONEHOT_CHECK_EN
    logic             err;

    modport master (
        output wr_en, wr_num1, wr_num2, wr_op, prog_clr, start, alu_out,
        input  on, in_sel, num1, num2, out_sel, res_valid, res_data, res_idx,
               busy, done, prog_full, prog_cnt, err
    );
    modport slave (
        input  wr_en, wr_num1, wr_num2, wr_op, prog_clr, start, alu_out,
        output on, in_sel, num1, num2, out_sel, res_valid, res_data, res_idx,
               busy, done, prog_full, prog_cnt, err
    );
`else
    modport master (
        output wr_en, wr_num1, wr_num2, wr_op, prog_clr, start, alu_out,
        input  on, in_sel, num1, num2, out_sel, res_valid, res_data, res_idx,
               busy, done, prog_full, prog_cnt
    );
    modport slave (
        input  wr_en, wr_num1, wr_num2, wr_op, prog_clr, start, alu_out,
        output on, in_sel, num1, num2, out_sel, res_valid, res_data, res_idx,
               busy, done, prog_full, prog_cnt
    );
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// Stores a program of {num1,num2,op} entries and replays it through an external ALU,
// capturing one result per entry. Define ALU_SEQ_ONEHOT_CHECK_EN to reject non-one-hot ops via err.
module alu_op_sequencer #(
    parameter int DEPTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_sequencer_if.slave bus,
    output logic [2:0]        dbg_state
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int ENT_W = 8 + 8 + 7;

    localparam logic [2:0] SEL_PERSIST = 3'b100;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_RESET   = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] prog_cnt_q, prog_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       wait_q, wait_d;
    logic [7:0]       num1_q, num1_d;
    logic [7:0]       num2_q, num2_d;
    logic [6:0]       out_sel_q, out_sel_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_data_q, res_data_d;
    logic [IDX_W-1:0] res_idx_q, res_idx_d;

    logic             run_active;
    logic             prog_full_w;
    logic             clr_accept;
    logic             wr_accept;
    logic             mem_we;
    logic             last_entry;
    logic [ENT_W-1:0] next_entry;

    assign run_active  = (state_q != S_IDLE);
    assign prog_full_w = (prog_cnt_q == CNT_W'(DEPTH));
    assign clr_accept  = bus.prog_clr && !run_active;
    assign wr_accept   = bus.wr_en && !run_active && !prog_full_w && !clr_accept;
    assign last_entry  = ({1'b0, idx_q} == (prog_cnt_q - CNT_W'(1)));

`ifdef ALU_SEQ_ONEHOT_CHECK_EN
    logic op_onehot;
    logic err_q, err_d;

    assign op_onehot = (bus.wr_op != 7'd0) && ((bus.wr_op & (bus.wr_op - 7'd1)) == 7'd0);
    assign mem_we    = wr_accept && op_onehot;

    always_comb begin
        err_d = err_q;
        if (clr_accept) begin
            err_d = 1'b0;
        end else if (wr_accept && !op_onehot) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign mem_we = wr_accept;
`endif

    // Program storage carries no reset; only prog_cnt decides which entries are live.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[prog_cnt_q[IDX_W-1:0]] <= {bus.wr_num1, bus.wr_num2, bus.wr_op};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (prog_cnt_q == '0) ? S_FIN : S_CLEAR;
                end
            end
            S_CLEAR:   state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT: begin
                if (wait_q == 3'(ALU_LAT - 1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: state_d = last_entry ? S_FIN : S_ISSUE;
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.on     = 1'b0;
        bus.in_sel = SEL_PERSIST;
        bus.done   = 1'b0;
        bus.busy   = 1'b1;
        case (state_q)
            S_IDLE:  bus.busy = 1'b0;
            S_CLEAR: begin
                bus.on     = 1'b1;
                bus.in_sel = SEL_RESET;
            end
            S_ISSUE: begin
                bus.on     = 1'b1;
                bus.in_sel = SEL_LOAD;
            end
            S_WAIT, S_CAPTURE: bus.on = 1'b1;
            S_FIN:   bus.done = 1'b1;
            default: bus.busy = 1'b0;
        endcase
    end

    // Operands are registered on the way into ISSUE so they are stable for the whole load/wait window.
    always_comb begin
        prog_cnt_d  = prog_cnt_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        out_sel_d   = out_sel_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;

        if (clr_accept) begin
            prog_cnt_d = '0;
        end else if (mem_we) begin
            prog_cnt_d = prog_cnt_q + CNT_W'(1);
        end

        if (state_q == S_CLEAR) begin
            idx_d = '0;
        end else if (state_q == S_CAPTURE && !last_entry) begin
            idx_d = idx_q + IDX_W'(1);
        end

        if (state_q == S_ISSUE) begin
            wait_d = 3'd0;
        end else if (state_q == S_WAIT) begin
            wait_d = wait_q + 3'd1;
        end

        next_entry = mem_q[idx_d];
        if (state_d == S_ISSUE) begin
            num1_d    = next_entry[22:15];
            num2_d    = next_entry[14:7];
            out_sel_d = next_entry[6:0];
        end

        if (state_q == S_CAPTURE) begin
            res_valid_d = 1'b1;
            res_data_d  = bus.alu_out;
            res_idx_d   = idx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog_cnt_q  <= '0;
            idx_q       <= '0;
            wait_q      <= 3'd0;
            num1_q      <= 8'd0;
            num2_q      <= 8'd0;
            out_sel_q   <= 7'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'd0;
            res_idx_q   <= '0;
        end else begin
            prog_cnt_q  <= prog_cnt_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            out_sel_q   <= out_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
        end
    end

    assign bus.num1      = num1_q;
    assign bus.num2      = num2_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_idx   = res_idx_q;
    assign bus.prog_cnt  = prog_cnt_q;
    assign bus.prog_full = prog_full_w;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: two instances (ALU_LAT 1 and 2) share one stimulus stream,
// each paired with a small ALU model; results are scoreboarded against hand-computed values.
module tb_alu_op_sequencer;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;
    localparam logic [63:0] RST_PACK = 64'({1'b0, 3'b100, 8'd0, 8'd0, 7'd0, 1'b0, 8'd0, 3'd0,
                                            1'b0, 1'b0, 4'd0, 1'b0});

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       wr_en, prog_clr, start;
    logic [7:0] wr_num1, wr_num2;
    logic [6:0] wr_op;
    logic [2:0] dbg1, dbg2;

    int errors = 0;
    int checks = 0;

    logic [IDX_W+7:0] exp1_q[$];
    logic [IDX_W+7:0] exp2_q[$];

    logic [7:0] n1_tab [8];
    logic [7:0] n2_tab [8];
    logic [6:0] op_tab [8];
    logic [7:0] res_tab[8];

    alu_op_sequencer_if #(.DEPTH(DEPTH)) if1 ();
    alu_op_sequencer_if #(.DEPTH(DEPTH)) if2 ();

    assign if1.wr_en = wr_en;     assign if2.wr_en = wr_en;
    assign if1.wr_num1 = wr_num1; assign if2.wr_num1 = wr_num1;
    assign if1.wr_num2 = wr_num2; assign if2.wr_num2 = wr_num2;
    assign if1.wr_op = wr_op;     assign if2.wr_op = wr_op;
    assign if1.prog_clr = prog_clr; assign if2.prog_clr = prog_clr;
    assign if1.start = start;     assign if2.start = start;

    alu_op_sequencer #(.DEPTH(DEPTH), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .dbg_state(dbg1)
    );
    alu_op_sequencer #(.DEPTH(DEPTH), .ALU_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .bus(if2), .dbg_state(dbg2)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [6:0] op);
        case (op)
            7'b1000000: return a + b;
            7'b0100000: return a - b;
            7'b0010000: return a & b;
            7'b0001000: return a | b;
            7'b0000100: return a ^ b;
            7'b0000010: return ~a;
            7'b0000001: return a;
            default:    return 8'h00;
        endcase
    endfunction

    // ALU models: result appears ALU_LAT-1 edges after the load edge, 8'h5A before that.
    logic [7:0] pend1, pend2;
    int rem1, rem2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend1 <= 8'd0;
            rem1  <= 0;
        end else if (if1.in_sel == 3'b001) begin
            pend1 <= 8'd0;
            rem1  <= 0;
        end else if (if1.in_sel == 3'b010) begin
            pend1 <= alu_f(if1.num1, if1.num2, if1.out_sel);
            rem1  <= 0;
        end else if (rem1 > 0) begin
            rem1 <= rem1 - 1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend2 <= 8'd0;
            rem2  <= 0;
        end else if (if2.in_sel == 3'b001) begin
            pend2 <= 8'd0;
            rem2  <= 0;
        end else if (if2.in_sel == 3'b010) begin
            pend2 <= alu_f(if2.num1, if2.num2, if2.out_sel);
            rem2  <= 1;
        end else if (rem2 > 0) begin
            rem2 <= rem2 - 1;
        end
    end
    assign if1.alu_out = (rem1 == 0) ? pend1 : 8'h5A;
    assign if2.alu_out = (rem2 == 0) ? pend2 : 8'h5A;

    function automatic logic [63:0] pack1();
        return 64'({if1.on, if1.in_sel, if1.num1, if1.num2, if1.out_sel, if1.res_valid,
                    if1.res_data, if1.res_idx, if1.busy, if1.done, if1.prog_cnt, if1.prog_full});
    endfunction

    function automatic logic [63:0] pack2();
        return 64'({if2.on, if2.in_sel, if2.num1, if2.num2, if2.out_sel, if2.res_valid,
                    if2.res_data, if2.res_idx, if2.busy, if2.done, if2.prog_cnt, if2.prog_full});
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [7:0] a, input logic [7:0] b, input logic [6:0] op);
        wr_en   = 1'b1;
        wr_num1 = a;
        wr_num2 = b;
        wr_op   = op;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic write_tab(input int k);
        write_entry(n1_tab[k], n2_tab[k], op_tab[k]);
    endtask

    task automatic clear_prog();
        prog_clr = 1'b1;
        tick();
        prog_clr = 1'b0;
    endtask

    // Starts a run of the first n table entries and watches both instances for a bounded window.
    task automatic run_prog(input int n, input bit chk_seq, input bit inject);
        logic [2:0] seq_tab[8];
        logic       on_tab[8];
        int lat1, lat2, dn1, dn2, iss, budget;
        bit on_seen;
        logic [IDX_W+7:0] e;
        seq_tab = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b100, 3'b100, 3'b100};
        on_tab  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        lat1 = 0; lat2 = 0; dn1 = 0; dn2 = 0; iss = 0; on_seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            exp1_q.push_back({3'(k), res_tab[k]});
            exp2_q.push_back({3'(k), res_tab[k]});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        budget = 2 + n * 4 + 4;
        for (int c = 1; c <= budget; c++) begin
            if (chk_seq && c <= 8) begin
                check("in_sel_seq", 64'(if1.in_sel), 64'(seq_tab[c-1]));
                check("on_seq", 64'(if1.on), 64'(on_tab[c-1]));
            end
            if (if1.in_sel == 3'b010 && iss < n) begin
                check("issue_num1", 64'(if1.num1), 64'(n1_tab[iss]));
                check("issue_num2", 64'(if1.num2), 64'(n2_tab[iss]));
                check("issue_op", 64'(if1.out_sel), 64'(op_tab[iss]));
                iss++;
            end
            if (if1.res_valid) begin
                e = (exp1_q.size() > 0) ? exp1_q.pop_front() : '1;
                check("res1", 64'({if1.res_idx, if1.res_data}), 64'(e));
            end
            if (if2.res_valid) begin
                e = (exp2_q.size() > 0) ? exp2_q.pop_front() : '1;
                check("res2", 64'({if2.res_idx, if2.res_data}), 64'(e));
            end
            if (if1.on) on_seen = 1'b1;
            if (if1.done) begin dn1++; lat1 = c; end
            if (if2.done) begin dn2++; lat2 = c; end
            if (inject && c == 5) begin
                start = 1'b1; wr_en = 1'b1; prog_clr = 1'b1;
                wr_num1 = 8'hEE; wr_num2 = 8'hEE; wr_op = 7'b0000001;
            end
            if (inject && c == 6) begin
                start = 1'b0; wr_en = 1'b0; prog_clr = 1'b0;
            end
            tick();
        end
        check("done_cnt1", 64'(dn1), 64'd1);
        check("done_cnt2", 64'(dn2), 64'd1);
        check("missing_res1", 64'(exp1_q.size()), 64'd0);
        check("missing_res2", 64'(exp2_q.size()), 64'd0);
        exp1_q.delete();
        exp2_q.delete();
        if (n > 0) begin
            check("lat1", 64'(lat1), 64'(2 + n * 3));
            check("lat2", 64'(lat2), 64'(2 + n * 4));
            check("issue_cnt", 64'(iss), 64'(n));
            check("res_hold", 64'({if1.res_idx, if1.res_data}), 64'({3'(n - 1), res_tab[n-1]}));
        end else begin
            check("empty_lat1", 64'(lat1 >= 1 && lat1 <= 2), 64'd1);
            check("empty_lat2", 64'(lat2 >= 1 && lat2 <= 2), 64'd1);
            check("empty_on", 64'(on_seen), 64'd0);
        end
        check("idle_busy1", 64'(if1.busy), 64'd0);
        check("idle_busy2", 64'(if2.busy), 64'd0);
    endtask

    initial begin
        n1_tab  = '{8'd87, 8'd87, 8'hF0, 8'hF0, 8'hF0, 8'h0F, 8'd200, 8'd5};
        n2_tab  = '{8'd26, 8'd26, 8'h3C, 8'h3C, 8'h3C, 8'h00, 8'd100, 8'd9};
        op_tab  = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0001000,
                    7'b0000100, 7'b0000010, 7'b1000000, 7'b0100000};
        res_tab = '{8'd113, 8'd61, 8'h30, 8'hFC, 8'hCC, 8'hF0, 8'd44, 8'd252};

        // Clock/reset
        rst = 1'b1; wr_en = 1'b0; prog_clr = 1'b0; start = 1'b0;
        wr_num1 = 8'd0; wr_num2 = 8'd0; wr_op = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs1", pack1(), RST_PACK);
        check("reset_outputs2", pack2(), RST_PACK);
`ifdef ALU_SEQ_ONEHOT_CHECK_EN
        check("reset_err", 64'(if1.err), 64'd0);
`endif
        rst = 1'b0;
        tick();

        // Two-entry program, then a replay of the same program
        write_tab(0);
        write_tab(1);
        check("cnt_after_2", 64'(if1.prog_cnt), 64'd2);
        check("full_after_2", 64'(if1.prog_full), 64'd0);
        run_prog(2, 1'b1, 1'b0);
        run_prog(2, 1'b1, 1'b0);
        check("cnt_after_runs", 64'(if1.prog_cnt), 64'd2);

        // Clear and write together: clear wins
        prog_clr = 1'b1; wr_en = 1'b1; wr_num1 = 8'd1; wr_num2 = 8'd2; wr_op = 7'b1000000;
        tick();
        prog_clr = 1'b0; wr_en = 1'b0;
        check("clr_wins", 64'(if1.prog_cnt), 64'd0);
        tick();
        check("clr_wins_hold", 64'(if2.prog_cnt), 64'd0);

        // Empty program: done without ALU activity
        run_prog(0, 1'b0, 1'b0);

        // Fill to DEPTH, then one extra write that must be dropped
        for (int k = 0; k < 7; k++) write_tab(k);
        check("cnt_7", 64'(if1.prog_cnt), 64'd7);
        check("full_7", 64'(if1.prog_full), 64'd0);
        write_tab(7);
        check("cnt_8", 64'(if1.prog_cnt), 64'd8);
        check("full_8", 64'(if1.prog_full), 64'd1);
        write_entry(8'hEE, 8'hEE, 7'b0000001);
        check("cnt_9th_ignored", 64'(if1.prog_cnt), 64'd8);

        // Full run with start/wr_en/prog_clr pulsed while busy
        run_prog(8, 1'b0, 1'b1);
        check("cnt_after_inject", 64'(if1.prog_cnt), 64'd8);
        check("cnt2_after_inject", 64'(if2.prog_cnt), 64'd8);

        // Reset during WAIT of entry 3
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("pre_rst_issue", 64'({if1.in_sel, if1.num1}), 64'({3'b010, n1_tab[3]}));
        tick();
        check("pre_rst_wait", 64'({if1.on, if1.in_sel}), 64'({1'b1, 3'b100}));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst1", pack1(), RST_PACK);
        check("async_rst2", pack2(), RST_PACK);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_no_done", 64'({if1.done, if2.done, if1.res_valid, if2.res_valid}), 64'd0);
        end
        rst = 1'b0;
        tick();
        check("post_rst_cnt", 64'(if1.prog_cnt), 64'd0);
        for (int k = 0; k < 3; k++) write_tab(k);
        run_prog(3, 1'b0, 1'b0);

`ifdef ALU_SEQ_ONEHOT_CHECK_EN
        // Non-one-hot op is rejected and flagged until prog_clr
        clear_prog();
        check("err_idle", 64'({if1.err, if2.err}), 64'd0);
        write_entry(8'd3, 8'd4, 7'b0000011);
        check("err_set", 64'({if1.err, if2.err}), 64'b11);
        check("err_cnt", 64'(if1.prog_cnt), 64'd0);
        write_tab(0);
        check("err_sticky", 64'(if1.err), 64'd1);
        check("err_cnt_ok", 64'(if1.prog_cnt), 64'd1);
        clear_prog();
        check("err_cleared", 64'({if1.err, if2.err}), 64'd0);
`else
        // Non-one-hot op is stored and issued unchanged
        n1_tab[0] = 8'd3; n2_tab[0] = 8'd4; op_tab[0] = 7'b0000011; res_tab[0] = 8'd0;
        clear_prog();
        write_tab(0);
        check("raw_op_cnt", 64'(if1.prog_cnt), 64'd1);
        run_prog(1, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter DEPTH, 8, number of program entries (power of two, 2..16).
REQ-002 Parameter ALU_LAT, 1, clocks from operand issue to valid ALU result (1..4).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 wr_en  in  1  append one program entry.
REQ-006 wr_num1, wr_num2  in  8 each  operands of the entry being written.
REQ-007 wr_op  in  7  one-hot operation select of the entry being written.
REQ-008 prog_clr  in  1  empty the program.
REQ-009 start  in  1  run the stored program once.
REQ-010 alu_out  in  8  result returned by the ALU.
REQ-011 on  out  1  ALU enable.
REQ-012 in_sel  out  3  ALU input mode: 100 persist, 010 load, 001 reset.
REQ-013 num1, num2  out  8 each  operands driven to the ALU.
REQ-014 out_sel  out  7  one-hot operation driven to the ALU.
REQ-015 res_valid  out  1  one-cycle pulse, res_data/res_idx valid.
REQ-016 res_data  out  8  captured ALU result; res_idx  out  $clog2(DEPTH)  entry index.
REQ-017 busy  out  1  run in progress; done  out  1  one-cycle end-of-run pulse.
REQ-018 prog_full  out  1  program holds DEPTH entries; prog_cnt  out  $clog2(DEPTH)+1  entry count.

Function
REQ-019 Program storage SHALL be a write-pointer array; wr_en with !busy and !prog_full writes {wr_num1,wr_num2,wr_op} at index prog_cnt and increments prog_cnt next cycle.
REQ-020 wr_en while busy or prog_full SHALL be ignored; no state change.
REQ-021 prog_clr while !busy SHALL set prog_cnt to 0 next cycle; prog_clr while busy SHALL be ignored; prog_clr and wr_en together: clear wins.
REQ-022 Program contents SHALL persist across runs; a second start replays the same entries.
REQ-023 FSM states: IDLE, CLEAR, ISSUE, WAIT, CAPTURE, FIN.
REQ-024 IDLE: on=0, in_sel=100, busy=0; start with prog_cnt>0 -> CLEAR; start with prog_cnt=0 -> FIN (no ALU activity).
REQ-025 CLEAR (1 cycle): on=1, in_sel=001, idx<=0 -> ISSUE.
REQ-026 ISSUE (1 cycle): on=1, in_sel=010, num1/num2/out_sel = entry[idx] -> WAIT.
REQ-027 WAIT: on=1, in_sel=100, operands held; stays ALU_LAT cycles -> CAPTURE.
REQ-028 CAPTURE (1 cycle): res_data<=alu_out, res_idx<=idx, res_valid pulses next cycle; if idx==prog_cnt-1 -> FIN else idx+1, -> ISSUE.
REQ-029 FIN (1 cycle): done pulses, on=0 -> IDLE.
REQ-030 busy SHALL be 1 in CLEAR, ISSUE, WAIT, CAPTURE, FIN; start while busy ignored.
REQ-031 Per-entry cost SHALL be exactly 2+ALU_LAT cycles; full run = 2+prog_cnt*(2+ALU_LAT) cycles start-to-done.
REQ-032 res_data and res_idx SHALL hold last value until next capture.
REQ-033 At DEPTH entries idx SHALL not wrap past DEPTH-1; run ends in FIN.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, on=0, in_sel=100, num1=num2=0, out_sel=0, res_valid=0, res_data=0, res_idx=0, busy=0, done=0, prog_cnt=0, prog_full=0.
REQ-035 rst mid-run SHALL abort without done or res_valid pulse; program array content is don't-care after reset.

Configuration
REQ-036 Macro ALU_SEQ_ONEHOT_CHECK_EN defined: extra output err (1 bit, reset 0); wr_op not exactly one-hot on an accepted write sets err sticky (cleared only by rst or prog_clr) and the entry is not stored.
REQ-037 Macro undefined: no err port; any wr_op value stored and issued unchanged.

Verification
REQ-038 Write entries {87,26,1000000},{87,26,0100000}, start, model ALU_LAT=1 -> in_sel 001,010,100 then 010,100; two res_valid pulses idx 0,1; done 8 cycles after start.
REQ-039 Write 8 entries -> prog_full=1, prog_cnt=8; 9th wr_en ignored; run gives res_idx 0..7 then done, 34 cycles start-to-done.
REQ-040 prog_cnt=0, start -> done pulse 2 cycles later, on stays 0, no res_valid.
REQ-041 Assert rst during WAIT of entry 3 -> all outputs reset asynchronously, no done; restart after rewrite runs cleanly.
REQ-042 start and wr_en while busy -> ignored, prog_cnt unchanged, run unaffected.
REQ-043 With ALU_SEQ_ONEHOT_CHECK_EN: wr_op=0000011 -> err=1, prog_cnt unchanged; prog_clr -> err=0.
